linkspeed_rx: RTL
=================

LINKSPEED_RX -- requirements
Module: linkspeed_rx

Interface
REQ-001 SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  LTSM enable for the LINKSPEED responder.
- i_sideband_message  in  4  decoded partner message.
- i_rx_valid  in  1  i_sideband_message valid this cycle.
- i_busy_negedge_detected  in  1  sideband finished transmitting the current message.
- i_point_test_ack  in  1  receive-side point test complete.
- o_sideband_message  out  4  response code to transmit.
- o_valid_rx  out  1  response valid to sideband.
- o_point_test_en  out  1  enable receive-side point test.
- o_test_ack  out  1  LINKSPEED responder finished.
- o_exit_cause  out  2  00 done, 01 repair, 10 speed degrade, 11 phy retrain.
- o_error_req_received  out  1  partner sent ERROR_REQ this pass.

REQ-002 SHALL use 4-bit codes:
- START_REQ 1, START_RESP 2, ERROR_REQ 3, ERROR_RESP 4.
- EXIT_TO_REPAIR_REQ 5, EXIT_TO_REPAIR_RESP 6, EXIT_TO_SPEED_DEGRADE_REQ 7, EXIT_TO_SPEED_DEGRADE_RESP 8.
- DONE_REQ 9, DONE_RESP 10, EXIT_TO_PHYRETRAIN_REQ 11, EXIT_TO_PHYRETRAIN_RESP 12.

Function
REQ-003 A message SHALL be accepted only in a cycle with i_rx_valid=1; codes not legal for the current state SHALL be ignored.

REQ-004 FSM states: IDLE, WAIT_START, POINT_TEST, WAIT_REQ, WAIT_EXIT, SEND_RESP, TEST_FINISHED.

REQ-005 IDLE->WAIT_START when i_en=1.

REQ-006 WAIT_START on START_REQ: ->POINT_TEST. In the next cycle, o_point_test_en=1, o_sideband_message=START_RESP and o_valid_rx=1 together.

REQ-007 POINT_TEST: on i_point_test_ack, o_point_test_en=0 in the next cycle and ->WAIT_REQ.

REQ-008 A DONE_REQ, ERROR_REQ or EXIT_TO_PHYRETRAIN_REQ accepted during POINT_TEST SHALL be latched in a one-entry pending register. It is processed on entry to WAIT_REQ. A later request overwrites an earlier one, except that EXIT_TO_PHYRETRAIN_REQ is never overwritten.

REQ-009 WAIT_REQ (live or pending request):
- DONE_REQ -> respond DONE_RESP, o_exit_cause=00.
- EXIT_TO_PHYRETRAIN_REQ -> respond EXIT_TO_PHYRETRAIN_RESP, o_exit_cause=11.
- ERROR_REQ -> respond ERROR_RESP, set o_error_req_received, ->WAIT_EXIT.

REQ-010 WAIT_EXIT:
- EXIT_TO_REPAIR_REQ -> EXIT_TO_REPAIR_RESP, cause 01.
- EXIT_TO_SPEED_DEGRADE_REQ -> EXIT_TO_SPEED_DEGRADE_RESP, cause 10.
- EXIT_TO_PHYRETRAIN_REQ -> EXIT_TO_PHYRETRAIN_RESP, cause 11.
- All three lead to SEND_RESP.

REQ-011 Response latency SHALL be one cycle from request acceptance to o_valid_rx=1, with o_sideband_message valid in the same cycle.

REQ-012 o_valid_rx SHALL hold until i_busy_negedge_detected=1, then clear on the next edge; o_sideband_message holds its value.

REQ-013 SEND_RESP->TEST_FINISHED on the cycle o_valid_rx clears. TEST_FINISHED drives o_test_ack=1 until i_en=0.

REQ-014 A new request arriving while o_valid_rx=1 SHALL be latched (REQ-008 rules) and answered no earlier than the cycle after o_valid_rx clears; responses are never overlapped.

REQ-015 i_en=0 in any state SHALL force ->IDLE on the next edge and clear all outputs, the pending register and the flags, including mid-response.

REQ-016 Simultaneous i_busy_negedge_detected and a new request in the same cycle: valid clears first, and the request is answered one cycle later.

Reset
REQ-017 On rst=1 at a clock edge: state=IDLE; all outputs 0; o_sideband_message=0; pending register empty.

REQ-018 rst SHALL take priority over i_en and over every input event.

Structure
REQ-019 Message codes, the o_exit_cause encoding and state encodings SHALL live in the shared ltsm_mbtrain_pkg, common with the transmit-side LINKSPEED block.

REQ-020 One sub-module is natural: sb_resp_driver. It holds the message/valid register and implements REQ-012, REQ-014 and REQ-016.

REQ-021 The design SHALL be 120-400 lines of RTL with no latches and full default assignments in combinational logic.

Verification
REQ-022 Clean pass: i_en=1, then START_REQ, then ack after 20 cycles, then DONE_REQ -> START_RESP (2) 1 cycle after START_REQ, DONE_RESP (10) 1 cycle after DONE_REQ, o_exit_cause=00, o_test_ack=1.

REQ-023 Repair path: ERROR_REQ then EXIT_TO_REPAIR_REQ -> responses 4 then 6, o_error_req_received=1, o_exit_cause=01.

REQ-024 Early request: DONE_REQ arrives 5 cycles before i_point_test_ack -> DONE_RESP valid 1 cycle after entry to WAIT_REQ.

REQ-025 Overlap: EXIT_TO_PHYRETRAIN_REQ arrives while START_RESP valid, then busy negedge -> 12 issued the cycle after valid clears, o_exit_cause=11.

REQ-026 Abort: i_en=0 during POINT_TEST with o_valid_rx=1 -> next cycle state IDLE and all outputs 0; an illegal code (e.g. 10) in WAIT_START is ignored.

Source files
------------

// File: rtl/ltsm_mbtrain_pkg.sv
// Shared LINKSPEED definitions: sideband message codes, FSM states, exit causes
// and the request-to-response mapping used by both link directions.
package ltsm_mbtrain_pkg;

    localparam logic [3:0] START_REQ                  = 4'd1;
    localparam logic [3:0] START_RESP                 = 4'd2;
    localparam logic [3:0] ERROR_REQ                  = 4'd3;
    localparam logic [3:0] ERROR_RESP                 = 4'd4;
    localparam logic [3:0] EXIT_TO_REPAIR_REQ         = 4'd5;
    localparam logic [3:0] EXIT_TO_REPAIR_RESP        = 4'd6;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_REQ  = 4'd7;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_RESP = 4'd8;
    localparam logic [3:0] DONE_REQ                   = 4'd9;
    localparam logic [3:0] DONE_RESP                  = 4'd10;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_REQ     = 4'd11;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_RESP    = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_POINT_TEST,
        ST_WAIT_REQ,
        ST_WAIT_EXIT,
        ST_SEND_RESP,
        ST_TEST_FINISHED
    } ls_state_e;

    typedef enum logic [1:0] {
        CAUSE_DONE    = 2'b00,
        CAUSE_REPAIR  = 2'b01,
        CAUSE_DEGRADE = 2'b10,
        CAUSE_RETRAIN = 2'b11
    } exit_cause_e;

    // Requests the responder acts on (or buffers) in a given state.
    function automatic logic is_req_legal(input ls_state_e st, input logic [3:0] code);
        logic legal;
        legal = 1'b0;
        case (st)
            ST_POINT_TEST, ST_WAIT_REQ:
                legal = code inside {DONE_REQ, ERROR_REQ, EXIT_TO_PHYRETRAIN_REQ};
            ST_WAIT_EXIT:
                legal = code inside {EXIT_TO_REPAIR_REQ, EXIT_TO_SPEED_DEGRADE_REQ,
                                     EXIT_TO_PHYRETRAIN_REQ};
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [3:0] resp_of(input logic [3:0] req);
        logic [3:0] resp;
        case (req)
            START_REQ:                 resp = START_RESP;
            ERROR_REQ:                 resp = ERROR_RESP;
            EXIT_TO_REPAIR_REQ:        resp = EXIT_TO_REPAIR_RESP;
            EXIT_TO_SPEED_DEGRADE_REQ: resp = EXIT_TO_SPEED_DEGRADE_RESP;
            DONE_REQ:                  resp = DONE_RESP;
            EXIT_TO_PHYRETRAIN_REQ:    resp = EXIT_TO_PHYRETRAIN_RESP;
            default:                   resp = 4'd0;
        endcase
        return resp;
    endfunction

    function automatic exit_cause_e cause_of(input logic [3:0] req);
        exit_cause_e cause;
        case (req)
            EXIT_TO_REPAIR_REQ:        cause = CAUSE_REPAIR;
            EXIT_TO_SPEED_DEGRADE_REQ: cause = CAUSE_DEGRADE;
            EXIT_TO_PHYRETRAIN_REQ:    cause = CAUSE_RETRAIN;
            default:                   cause = CAUSE_DONE;
        endcase
        return cause;
    endfunction

endpackage

// File: rtl/linkspeed_rx_if.sv
// Signal bundle between the LTSM/sideband side (master) and the LINKSPEED
// responder (slave); state is a debug view of the responder FSM.
interface linkspeed_rx_if;

    logic       i_en;
    logic [3:0] i_sideband_message;
    logic       i_rx_valid;
    logic       i_busy_negedge_detected;
    logic       i_point_test_ack;
    logic [3:0] o_sideband_message;
    logic       o_valid_rx;
    logic       o_point_test_en;
    logic       o_test_ack;
    logic [1:0] o_exit_cause;
    logic       o_error_req_received;
    ltsm_mbtrain_pkg::ls_state_e state;

    modport master (
        output i_en, i_sideband_message, i_rx_valid, i_busy_negedge_detected, i_point_test_ack,
        input  o_sideband_message, o_valid_rx, o_point_test_en, o_test_ack, o_exit_cause,
        input  o_error_req_received, state
    );

    modport slave (
        input  i_en, i_sideband_message, i_rx_valid, i_busy_negedge_detected, i_point_test_ack,
        output o_sideband_message, o_valid_rx, o_point_test_en, o_test_ack, o_exit_cause,
        output o_error_req_received, state
    );

endinterface

// File: rtl/sb_resp_driver.sv
// Response register toward the sideband: one message in flight at a time,
// held until the sideband reports it has finished transmitting it.
module sb_resp_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       issue,
    input  logic [3:0] issue_code,
    input  logic       busy_negedge,
    output logic [3:0] msg,
    output logic       valid
);

    // Handshake: valid rises the edge after issue and stays high until
    // busy_negedge is seen while valid; issue is ignored while valid is high,
    // so a clearing cycle never loads a new message. msg holds after clearing.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            msg   <= 4'd0;
            valid <= 1'b0;
        end else if (valid) begin
            if (busy_negedge) valid <= 1'b0;
        end else if (issue) begin
            msg   <= issue_code;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/linkspeed_rx.sv
// LINKSPEED responder: answers partner requests after the receive point test,
// buffering one early/overlapping request and reporting the exit cause.
module linkspeed_rx
    import ltsm_mbtrain_pkg::*;
(
    input logic           clk,
    input logic           rst,
    linkspeed_rx_if.slave bus
);

    ls_state_e   state, state_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [3:0]  pend_code, pend_code_nxt;
    exit_cause_e cause, cause_nxt;
    logic        err_flag, err_flag_nxt;
    logic        issue;
    logic [3:0]  issue_code;
    logic        resp_valid;
    logic [3:0]  resp_msg;
    logic        live_req;
    logic        serve;
    logic [3:0]  req_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pend_valid <= 1'b0;
            pend_code  <= 4'd0;
            cause      <= CAUSE_DONE;
            err_flag   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pend_valid <= pend_valid_nxt;
            pend_code  <= pend_code_nxt;
            cause      <= cause_nxt;
            err_flag   <= err_flag_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pend_valid_nxt = pend_valid;
        pend_code_nxt  = pend_code;
        cause_nxt      = cause;
        err_flag_nxt   = err_flag;
        issue          = 1'b0;
        issue_code     = 4'd0;
        serve          = 1'b0;
        live_req       = bus.i_rx_valid && is_req_legal(state, bus.i_sideband_message);
        req_code       = pend_valid ? pend_code : bus.i_sideband_message;
        if (!bus.i_en) begin
            state_nxt      = ST_IDLE;
            pend_valid_nxt = 1'b0;
            pend_code_nxt  = 4'd0;
            cause_nxt      = CAUSE_DONE;
            err_flag_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_WAIT_START;
                ST_WAIT_START:
                    if (bus.i_rx_valid && bus.i_sideband_message == START_REQ) begin
                        state_nxt  = ST_POINT_TEST;
                        issue      = 1'b1;
                        issue_code = START_RESP;
                    end
                ST_POINT_TEST: if (bus.i_point_test_ack) state_nxt = ST_WAIT_REQ;
                ST_WAIT_REQ, ST_WAIT_EXIT: serve = !resp_valid && (pend_valid || live_req);
                ST_SEND_RESP: if (resp_valid && bus.i_busy_negedge_detected) state_nxt = ST_TEST_FINISHED;
                default: ;
            endcase
            // A buffered request always wins over a live one in the same cycle.
            if (serve) begin
                issue          = 1'b1;
                issue_code     = resp_of(req_code);
                pend_valid_nxt = 1'b0;
                if (req_code == ERROR_REQ) begin
                    err_flag_nxt = 1'b1;
                    state_nxt    = ST_WAIT_EXIT;
                end else begin
                    cause_nxt = cause_of(req_code);
                    state_nxt = ST_SEND_RESP;
                end
            end else if (live_req && !(pend_valid && pend_code == EXIT_TO_PHYRETRAIN_REQ)) begin
                pend_valid_nxt = 1'b1;
                pend_code_nxt  = bus.i_sideband_message;
            end
        end
    end

    sb_resp_driver u_resp (
        .clk          (clk),
        .rst          (rst),
        .clr          (!bus.i_en),
        .issue        (issue),
        .issue_code   (issue_code),
        .busy_negedge (bus.i_busy_negedge_detected),
        .msg          (resp_msg),
        .valid        (resp_valid)
    );

    assign bus.o_sideband_message   = resp_msg;
    assign bus.o_valid_rx           = resp_valid;
    assign bus.o_point_test_en      = (state == ST_POINT_TEST);
    assign bus.o_test_ack           = (state == ST_TEST_FINISHED);
    assign bus.o_exit_cause         = cause;
    assign bus.o_error_req_received = err_flag;
    assign bus.state                = state;

endmodule
